rf_writeback_ctrl: RTL
======================

Name: rf_writeback_ctrl

Overview:
Write-back side of the 32x32 register file. Accepts results from the ALU (valid/ready) and from the load unit (valid only, cannot stall), formats load data, and arbitrates between them. Drives the register-file write port (write_reg/write_enable/write_data) from registers. Publishes a pending-destination mask so decode can stall on read-after-write hazards.

Parameters:
DEPTH, 2, ALU result buffer entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  buffer can accept ALU result
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
ld_valid  input  1  load response this cycle, single-cycle pulse
ld_rd  input  5  load destination register
ld_data  input  XLEN  raw aligned memory word
ld_funct3  input  3  load type (RV32I encoding)
ld_offset  input  2  byte address [1:0]
rf_we  output  1  to register file write_enable
rf_waddr  output  5  to register file write_reg
rf_wdata  output  XLEN  to register file write_data
pend_mask  output  32  bit i set while a buffered ALU write to xi is outstanding
ld_err  output  1  one-cycle pulse: illegal or misaligned load
wb_count  output  32  committed register writes since reset

Behaviour:
- Reset (clk edge with reset=1): buffer emptied, rf_we=0, rf_waddr=0, rf_wdata=0, ld_err=0, wb_count=0, pend_mask=0. Reset mid-operation discards all buffered entries and any load present that cycle.
- ALU channel: transfer when alu_valid && alu_ready. alu_ready = !full, computed combinationally from the registered count only. A pop in the same cycle does not raise alu_ready, so no push while full.
- Buffer: FIFO with DEPTH entries, wrap-around read/write pointers, and an occupancy count 0..DEPTH. Push and pop in the same cycle leave the count unchanged.
- Arbitration, per cycle:
  - If ld_valid, the load is selected.
  - Otherwise, if the FIFO is non-empty, the head is popped.
  - Load always wins, and the ALU head waits.
- Latency: the selected write appears on rf_we/rf_waddr/rf_wdata at the next clock edge, registered, and is held for one cycle. rf_we=0 in cycles with nothing selected. rf_waddr/rf_wdata hold their last value when rf_we=0.
- x0: a selected entry with rd=0 is consumed, popped or dropped, but rf_we stays 0 and wb_count does not increment.
- Load formatting, lane = ld_offset:
  - 000 LB: sign-extend byte[lane].
  - 100 LBU: zero-extend byte[lane].
  - 001 LH: sign-extend half[offset[1]]; requires offset[0]=0.
  - 101 LHU: zero-extend the same half; requires offset[0]=0.
  - 010 LW: full word; requires offset=00.
  - Any other funct3, or a misaligned offset: no write, ld_err=1 on the next cycle. The FIFO does not pop in that cycle.
- pend_mask: OR of decoded rd over valid FIFO entries, excluding rd=0, from registered state. A bit clears the cycle after its entry is popped. Duplicate rd entries keep the bit set until the last one pops.
- wb_count increments by 1 on each cycle rf_we=1 and wraps at 2^32.

Test Plan:
- Reset, then alu push rd=5 data=0x11 -> next edge rf_we=1, waddr=5, wdata=0x11. pend_mask bit5 set for one cycle, then clears. wb_count=1.
- LB, ld_data=0x80FF7F01, offset=3 -> wdata=0xFFFFFF80. LBU offset=2 -> 0x000000FF. LH offset=2 -> 0xFFFF80FF. LHU offset=0 -> 0x00007F01.
- ALU pushes rd=7 then rd=8 while ld_valid is held for 3 cycles (rd=9) -> three writes to x9, then x7, then x8. alu_ready=0 once 2 entries are buffered. A third ALU offer stalls and is accepted after the first pop.
- ALU rd=0 data=0xDEAD -> no rf_we, wb_count unchanged, alu_ready recovers. LW offset=01 -> ld_err pulse, no write.
- Reset asserted with 2 entries buffered -> buffer empty, pend_mask=0, alu_ready=1, rf_we=0 on the following cycle.
- Random mix of 1000 ALU/load events vs a reference model -> identical write sequence, alu_ready never high when full, no write ever to x0.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-back controller: buffers ALU results, formats load data,
// arbitrates with load priority and drives a registered write port.
module rf_writeback_ctrl #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ld_valid_i,
  input  logic [4:0]      ld_rd_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_offset_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [31:0]     pend_mask_o,
  output logic            ld_err_o,
  output logic [31:0]     wb_count_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            rf_we_q, rf_we_d, ld_err_q, ld_err_d;
  logic [4:0]      rf_waddr_q, sel_rd;
  logic [XLEN-1:0] rf_wdata_q, sel_data, ld_fmt;
  logic [31:0]     wb_count_q;
  logic            push, pop, ld_ok, sel_valid;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign alu_ready_o = (count_q != CW'(DEPTH));
  assign push        = alu_valid_i && alu_ready_o;
  // A load owns the write port this cycle, even an illegal one.
  assign pop         = !ld_valid_i && (count_q != '0);

  assign ld_byte = ld_data_i[{ld_offset_i, 3'b000} +: 8];
  assign ld_half = ld_data_i[{ld_offset_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_ok  = 1'b1;
    ld_fmt = '0;
    unique case (ld_funct3_i)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_ok  = !ld_offset_i[0];
      end
      3'b101: begin
        ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
        ld_ok  = !ld_offset_i[0];
      end
      3'b010: begin
        ld_fmt = ld_data_i;
        ld_ok  = (ld_offset_i == 2'b00);
      end
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (ld_valid_i) begin
      sel_valid = ld_ok;
      sel_rd    = ld_rd_i;
      sel_data  = ld_fmt;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = rd_mem_q[rptr_q];
      sel_data  = data_mem_q[rptr_q];
    end
    rf_we_d  = sel_valid && (sel_rd != 5'd0);
    ld_err_d = ld_valid_i && !ld_ok;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    logic [AW-1:0] idx;
    idx         = '0;
    pend_mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rptr_q + AW'(i);
      if ((CW'(i) < count_q) && (rd_mem_q[idx] != 5'd0)) pend_mask_o[rd_mem_q[idx]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= alu_rd_i;
      data_mem_q[wptr_q] <= alu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ld_err_q   <= 1'b0;
      wb_count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      rf_we_q  <= rf_we_d;
      ld_err_q <= ld_err_d;
      if (rf_we_d) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
      end
      if (rf_we_q) wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign ld_err_o   = ld_err_q;
  assign wb_count_o = wb_count_q;

endmodule
